// File: rtl/bus_arbiter_if.sv
// Bundles the per-master request/response signals and the single slave bus
// port of bus_arbiter. The arbiter uses the slave modport; the environment uses master.
interface bus_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDRWIDTH   = 16,
  parameter int DATAWIDTH   = 32
);
  logic [NUM_MASTERS*ADDRWIDTH-1:0] m_addr;
  logic [NUM_MASTERS*DATAWIDTH-1:0] m_wr_data;
  logic [NUM_MASTERS-1:0]           m_we;
  logic [NUM_MASTERS-1:0]           m_re;
  logic [DATAWIDTH-1:0]             m_rd_data;
  logic [NUM_MASTERS-1:0]           m_rd_ack;
  logic [NUM_MASTERS-1:0]           m_overrun;
  logic                             m_timeout;

  logic [ADDRWIDTH-1:0]             bus_addr;
  logic [DATAWIDTH-1:0]             bus_wr_data;
  logic                             bus_we;
  logic                             bus_re;
  logic [DATAWIDTH-1:0]             bus_rd_data;
  logic                             bus_rd_ack;

  modport slave (
    input  m_addr, m_wr_data, m_we, m_re, bus_rd_data, bus_rd_ack,
    output m_rd_data, m_rd_ack, m_overrun, m_timeout,
           bus_addr, bus_wr_data, bus_we, bus_re
  );

  modport master (
    output m_addr, m_wr_data, m_we, m_re, bus_rd_data, bus_rd_ack,
    input  m_rd_data, m_rd_ack, m_overrun, m_timeout,
           bus_addr, bus_wr_data, bus_we, bus_re
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one pulse-style chip bus between NUM_MASTERS masters.
// Optional read-ack timeout enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDRWIDTH   = 16,
  parameter int DATAWIDTH   = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic          clk,
  input  logic          reset_l,
  bus_arbiter_if.slave  io_bus
);

  localparam int IDXW = $clog2(NUM_MASTERS);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("bus_arbiter: unsupported parameter set");
  end

  typedef enum logic {S_IDLE, S_WAIT_ACK} state_t;

  state_t                 r_state, w_state_nxt;
  logic [NUM_MASTERS-1:0] r_slot_vld;
  logic [NUM_MASTERS-1:0] r_slot_wr;
  logic [ADDRWIDTH-1:0]   r_slot_addr [NUM_MASTERS];
  logic [DATAWIDTH-1:0]   r_slot_data [NUM_MASTERS];
  logic [IDXW-1:0]        r_rr, r_owner;

  logic [ADDRWIDTH-1:0]   r_bus_addr;
  logic [DATAWIDTH-1:0]   r_bus_wr_data;
  logic                   r_bus_we, r_bus_re;
  logic [DATAWIDTH-1:0]   r_m_rd_data;
  logic [NUM_MASTERS-1:0] r_m_rd_ack, r_m_overrun;

  logic                   w_win_vld, w_grant, w_win_wr, w_ack, w_timeout;
  logic [IDXW-1:0]        w_win_idx;
  logic [NUM_MASTERS-1:0] w_req, w_granted, w_load, w_overrun;

  // Scan slots above the last winner first, then wrap from slot 0.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_win_vld = 1'b0;
    w_win_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!w_win_vld && r_slot_vld[i] && i > int'(r_rr)) begin
        w_win_vld = 1'b1;
        w_win_idx = IDXW'(i);
      end
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!w_win_vld && r_slot_vld[i] && i <= int'(r_rr)) begin
        w_win_vld = 1'b1;
        w_win_idx = IDXW'(i);
      end
    end
  end

  assign w_grant   = (r_state == S_IDLE) && w_win_vld;
  assign w_win_wr  = r_slot_wr[w_win_idx];
  assign w_granted = w_grant ? (NUM_MASTERS'(1) << w_win_idx) : '0;
  assign w_req     = io_bus.m_we | io_bus.m_re;
  assign w_load    = w_req & (~r_slot_vld | w_granted);
  assign w_overrun = w_req & r_slot_vld & ~w_granted;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_m_timeout;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_ack       = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant && !w_win_wr) w_state_nxt = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (io_bus.bus_rd_ack) begin
          w_ack       = 1'b1;
          w_state_nxt = S_IDLE;
        end
`ifdef BUS_ARB_TIMEOUT_EN
        else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_ack       = 1'b1;
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_state       <= S_IDLE;
      r_slot_vld    <= '0;
      r_rr          <= IDXW'(NUM_MASTERS - 1);
      r_owner       <= '0;
      r_bus_addr    <= '0;
      r_bus_wr_data <= '0;
      r_bus_we      <= 1'b0;
      r_bus_re      <= 1'b0;
      r_m_rd_data   <= '0;
      r_m_rd_ack    <= '0;
      r_m_overrun   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_slot_vld  <= (r_slot_vld & ~w_granted) | w_load;
      r_bus_we    <= w_grant && w_win_wr;
      r_bus_re    <= w_grant && !w_win_wr;
      r_m_overrun <= w_overrun;
      r_m_rd_ack  <= w_ack ? (NUM_MASTERS'(1) << r_owner) : '0;
      if (w_grant) begin
        r_rr       <= w_win_idx;
        r_bus_addr <= r_slot_addr[w_win_idx];
        if (w_win_wr) r_bus_wr_data <= r_slot_data[w_win_idx];
        else          r_owner       <= w_win_idx;
      end
      if (w_ack) r_m_rd_data <= w_timeout ? '1 : io_bus.bus_rd_data;
    end
  end

  // NOTE: slot payload is storage qualified by r_slot_vld, so it carries no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (w_load[i]) begin
        r_slot_addr[i] <= io_bus.m_addr[i*ADDRWIDTH +: ADDRWIDTH];
        r_slot_data[i] <= io_bus.m_wr_data[i*DATAWIDTH +: DATAWIDTH];
        r_slot_wr[i]   <= io_bus.m_we[i];
      end
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_cnt       <= '0;
      r_m_timeout <= 1'b0;
    end else begin
      r_m_timeout <= w_timeout;
      if (w_grant && !w_win_wr)     r_cnt <= '0;
      else if (r_state == S_WAIT_ACK) r_cnt <= r_cnt + CNT_W'(1);
    end
  end
  assign io_bus.m_timeout = r_m_timeout;
`else
  assign io_bus.m_timeout = 1'b0;
`endif

  assign io_bus.bus_addr    = r_bus_addr;
  assign io_bus.bus_wr_data = r_bus_wr_data;
  assign io_bus.bus_we      = r_bus_we;
  assign io_bus.bus_re      = r_bus_re;
  assign io_bus.m_rd_data   = r_m_rd_data;
  assign io_bus.m_rd_ack    = r_m_rd_ack;
  assign io_bus.m_overrun   = r_m_overrun;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: expected bus transactions and master acks are
// queued when stimulus is driven and compared when the DUT emits them.
module tb_bus_arbiter;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] data;
  } bus_exp_t;

  typedef struct packed {
    logic [1:0]  ack;
    logic [31:0] data;
    logic        to;
  } ack_exp_t;

  logic clk = 1'b0;
  logic reset_l;

  bus_arbiter_if #(.NUM_MASTERS(2), .ADDRWIDTH(16), .DATAWIDTH(32)) u_if ();

  bus_arbiter #(.NUM_MASTERS(2), .ADDRWIDTH(16), .DATAWIDTH(32), .TIMEOUT(TO)) u_dut (
    .clk     (clk),
    .reset_l (reset_l),
    .io_bus  (u_if)
  );

  always #5 clk = ~clk;

  int       n_cmp = 0;
  int       n_err = 0;
  int       cyc = 0;
  int       last_ack_cyc = 0;
  int       last_we_cyc = 0;
  int       ack_events = 0;
  int       ovr_cnt [2] = '{0, 0};
  bus_exp_t exp_bus [$];
  ack_exp_t exp_ack [$];

  int          ack_delay = 0;
  int          ack_cnt = 0;
  logic [31:0] ack_data = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Slave model: acks ack_delay cycles after seeing bus_re (0 = never acks).
  always @(negedge clk) begin
    u_if.bus_rd_ack = 1'b0;
    if (ack_cnt > 0) begin
      ack_cnt--;
      if (ack_cnt == 0) begin
        u_if.bus_rd_ack  = 1'b1;
        u_if.bus_rd_data = ack_data;
      end
    end
    if (u_if.bus_re && ack_delay > 0) ack_cnt = ack_delay;
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    bus_exp_t eb;
    ack_exp_t ea;
    if (reset_l) begin
      if (u_if.bus_we || u_if.bus_re) begin
        if (exp_bus.size() == 0) begin
          check("bus_unexpected", {u_if.bus_we, u_if.bus_re}, 2'b00);
        end else begin
          eb = exp_bus.pop_front();
          check("bus_we", u_if.bus_we, eb.wr);
          check("bus_re", u_if.bus_re, !eb.wr);
          check("bus_addr", u_if.bus_addr, eb.addr);
          if (eb.wr) check("bus_wr_data", u_if.bus_wr_data, eb.data);
        end
        if (u_if.bus_we) last_we_cyc = cyc;
      end
      if (u_if.m_rd_ack != 0 || u_if.m_timeout) begin
        ack_events++;
        last_ack_cyc = cyc;
        if (exp_ack.size() == 0) begin
          check("ack_unexpected", {u_if.m_rd_ack, u_if.m_timeout}, 3'b000);
        end else begin
          ea = exp_ack.pop_front();
          check("m_rd_ack", u_if.m_rd_ack, ea.ack);
          check("m_rd_data", u_if.m_rd_data, ea.data);
          check("m_timeout", u_if.m_timeout, ea.to);
        end
      end
      for (int i = 0; i < 2; i++) if (u_if.m_overrun[i]) ovr_cnt[i]++;
    end
  end

  task automatic set_req(input int i, input logic [15:0] a, input logic [31:0] d);
    u_if.m_addr[i*16 +: 16]    = a;
    u_if.m_wr_data[i*32 +: 32] = d;
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_bus_addr"}, u_if.bus_addr, 0);
    check({pfx, "_bus_wr_data"}, u_if.bus_wr_data, 0);
    check({pfx, "_bus_we"}, u_if.bus_we, 0);
    check({pfx, "_bus_re"}, u_if.bus_re, 0);
    check({pfx, "_m_rd_data"}, u_if.m_rd_data, 0);
    check({pfx, "_m_rd_ack"}, u_if.m_rd_ack, 0);
    check({pfx, "_m_overrun"}, u_if.m_overrun, 0);
    check({pfx, "_m_timeout"}, u_if.m_timeout, 0);
  endtask

  // Both wait tasks are entered and return #1 after a rising edge.
  task automatic wait_bus(input string tag);
    int n = 0;
    while (!(u_if.bus_we || u_if.bus_re) && n < 30) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 30) check({tag, "_bus_wait_bound"}, 1, 0);
  endtask

  task automatic wait_ack(input string tag, output int n);
    n = 0;
    while (u_if.m_rd_ack == 0 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 40) check({tag, "_ack_wait_bound"}, 1, 0);
  endtask

  initial begin
    int n;
    int ov0, ov1, ev0;

    reset_l          = 1'b0;
    u_if.m_addr      = '0;
    u_if.m_wr_data   = '0;
    u_if.m_we        = '0;
    u_if.m_re        = '0;
    u_if.bus_rd_data = '0;
    u_if.bus_rd_ack  = 1'b0;

    repeat (2) @(posedge clk);
    #2;
    check_zero("reset");
    reset_l = 1'b1;

    // Single write from master 0: bus_we exactly one cycle, two edges after request.
    @(posedge clk); #1;
    set_req(0, 16'h0010, 32'hA5A5_0001);
    u_if.m_we = 2'b01;
    exp_bus.push_back('{1'b1, 16'h0010, 32'hA5A5_0001});
    @(posedge clk); #1;
    u_if.m_we = 2'b00;
    check("t1_we_after_T0", u_if.bus_we, 0);
    @(posedge clk); #1;
    check("t1_we_after_T1", u_if.bus_we, 1);
    @(posedge clk); #1;
    check("t1_we_single", u_if.bus_we, 0);
    check("t1_no_ack", u_if.m_rd_ack, 0);

    // Read from master 1, slave acks 3 cycles after bus_re.
    ack_delay = 3;
    ack_data  = 32'h1234_5678;
    @(posedge clk); #1;
    set_req(1, 16'h0020, 32'h0);
    u_if.m_re = 2'b10;
    exp_bus.push_back('{1'b0, 16'h0020, 32'h0});
    exp_ack.push_back('{2'b10, 32'h1234_5678, 1'b0});
    @(posedge clk); #1;
    u_if.m_re = 2'b00;
    wait_bus("t2");
    check("t2_bus_re", u_if.bus_re, 1);
    wait_ack("t2", n);
    check("t2_ack_latency", n, 4);
    check("t2_ack_vec", u_if.m_rd_ack, 2'b10);
    ack_delay = 0;
    repeat (2) @(posedge clk);
    #1;
    check("t2_rd_data_hold", u_if.m_rd_data, 32'h1234_5678);

    // Both masters write together three times; grants alternate 0,1,0,1,0,1.
    ov0 = ovr_cnt[0];
    ov1 = ovr_cnt[1];
    for (int p = 0; p < 3; p++) begin
      @(posedge clk); #1;
      set_req(0, 16'h0100 + 16'(p), 32'hA000_0000 + 32'(p));
      set_req(1, 16'h0200 + 16'(p), 32'hB000_0000 + 32'(p));
      u_if.m_we = 2'b11;
      exp_bus.push_back('{1'b1, 16'h0100 + 16'(p), 32'hA000_0000 + 32'(p)});
      exp_bus.push_back('{1'b1, 16'h0200 + 16'(p), 32'hB000_0000 + 32'(p)});
      @(posedge clk); #1;
      u_if.m_we = 2'b00;
    end
    repeat (6) @(posedge clk);
    #1;
    check("t3_drained", exp_bus.size(), 0);
    check("t3_no_ovr0", ovr_cnt[0] - ov0, 0);
    check("t3_no_ovr1", ovr_cnt[1] - ov1, 0);

    // Master 0 read with slow ack; two writes during WAIT_ACK, second dropped.
    ack_delay = 10;
    ack_data  = 32'hCAFE_0004;
    ov0 = ovr_cnt[0];
    @(posedge clk); #1;
    set_req(0, 16'h0030, 32'h0);
    u_if.m_re = 2'b01;
    exp_bus.push_back('{1'b0, 16'h0030, 32'h0});
    exp_ack.push_back('{2'b01, 32'hCAFE_0004, 1'b0});
    exp_bus.push_back('{1'b1, 16'h0040, 32'hD100_0001});
    @(posedge clk); #1;
    u_if.m_re = 2'b00;
    wait_bus("t4_rd");
    @(posedge clk); #1;
    set_req(0, 16'h0040, 32'hD100_0001);
    u_if.m_we = 2'b01;
    @(posedge clk); #1;
    set_req(0, 16'h0044, 32'hD200_0002);
    @(posedge clk); #1;
    u_if.m_we = 2'b00;
    wait_ack("t4", n);
    ack_delay = 0;
    @(posedge clk); #1;
    wait_bus("t4_wr");
    @(negedge clk); #1;
    check("t4_overrun_once", ovr_cnt[0] - ov0, 1);
    check("t4_wr_after_ack", last_we_cyc - last_ack_cyc, 1);

`ifdef BUS_ARB_TIMEOUT_EN
    // Master 1 read never acked: timeout returns all ones, then master 0 write issues.
    @(posedge clk); #1;
    set_req(1, 16'h0050, 32'h0);
    set_req(0, 16'h0060, 32'hE000_0006);
    u_if.m_re = 2'b10;
    u_if.m_we = 2'b01;
    exp_bus.push_back('{1'b0, 16'h0050, 32'h0});
    exp_ack.push_back('{2'b10, 32'hFFFF_FFFF, 1'b1});
    exp_bus.push_back('{1'b1, 16'h0060, 32'hE000_0006});
    @(posedge clk); #1;
    u_if.m_re = 2'b00;
    u_if.m_we = 2'b00;
    wait_bus("t5_rd");
    check("t5_bus_re", u_if.bus_re, 1);
    wait_ack("t5", n);
    check("t5_timeout_latency", n, TO);
    check("t5_timeout_pulse", u_if.m_timeout, 1);
    @(posedge clk); #1;
    wait_bus("t5_wr");
    check("t5_next_write", u_if.bus_we, 1);
`endif

    // Reset asynchronously mid-WAIT_ACK; the late ack must not reach any master.
    ack_delay = 6;
    ack_data  = 32'hDEAD_0006;
    @(posedge clk); #1;
    set_req(0, 16'h0070, 32'h0);
    u_if.m_re = 2'b01;
    exp_bus.push_back('{1'b0, 16'h0070, 32'h0});
    @(posedge clk); #1;
    u_if.m_re = 2'b00;
    wait_bus("t6_rd");
    @(posedge clk); #1;
    @(posedge clk); #3;
    reset_l = 1'b0;
    #1;
    check_zero("t6_async");
    ack_delay = 0;
    ev0 = ack_events;
    @(posedge clk);
    @(posedge clk); #3;
    reset_l = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("t6_no_late_ack", ack_events - ev0, 0);

    // Arbiter still functional after reset.
    @(posedge clk); #1;
    set_req(1, 16'h0080, 32'hF000_0008);
    u_if.m_we = 2'b10;
    exp_bus.push_back('{1'b1, 16'h0080, 32'hF000_0008});
    @(posedge clk); #1;
    u_if.m_we = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("end_bus_drained", exp_bus.size(), 0);
    check("end_ack_drained", exp_ack.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the internal chip bus (addr / wr_data / we / re / rd_data / rd_ack) between NUM_MASTERS pulse-style masters, e.g. the SPI slave and a debug UART master.
- Each master fires single-cycle we/re pulses with no back-pressure. The arbiter latches them, grants round-robin and issues one transaction at a time to the slave bus.
- Read data and ack are routed back to the originating master only.

Parameters:
- NUM_MASTERS, 2, number of requesters (2..8)
- ADDRWIDTH, 16, bus address width
- DATAWIDTH, 32, bus data width
- TIMEOUT, 255, read-ack timeout in clk cycles (used only with the optional feature)

Ports:
- clk  input  1  system clock
- reset_l  input  1  asynchronous active-low reset
- m_addr  input  NUM_MASTERS*ADDRWIDTH  packed per-master address; master i at [i*ADDRWIDTH +: ADDRWIDTH]
- m_wr_data  input  NUM_MASTERS*DATAWIDTH  packed per-master write data
- m_we  input  NUM_MASTERS  per-master write pulse
- m_re  input  NUM_MASTERS  per-master read pulse
- m_rd_data  output  DATAWIDTH  read data, shared by all masters, valid with m_rd_ack
- m_rd_ack  output  NUM_MASTERS  one-hot read-ack pulse
- m_overrun  output  NUM_MASTERS  pulse: master i's new request was dropped
- bus_addr  output  ADDRWIDTH  slave bus address
- bus_wr_data  output  DATAWIDTH  slave bus write data
- bus_we  output  1  slave write pulse
- bus_re  output  1  slave read pulse
- bus_rd_data  input  DATAWIDTH  slave read data
- bus_rd_ack  input  1  slave read ack pulse
- m_timeout  output  1  read-timeout pulse (tied 0 without the optional feature)

Behaviour:
- Reset (async, reset_l low): all outputs 0, all pending slots clear, state IDLE, rr pointer = NUM_MASTERS-1 (master 0 has first priority). Applies at any time, including mid-WAIT_ACK; the in-flight read is abandoned and no ack is returned.
- Capture, per master i, each clk edge:
  - m_we[i] or m_re[i] with slot i empty, or slot i being granted this edge: load slot {addr, wr_data, is_write = m_we[i]}. If both m_we and m_re are high, write wins and the read is discarded silently.
  - Slot occupied and not granted this edge: new request dropped, old one kept, m_overrun[i] pulses 1 cycle.
- Arbitration: scan slots starting at rr+1 modulo NUM_MASTERS; the first occupied slot wins. rr <= winner. The winning slot is cleared at the same edge.
- bus_we, bus_re, m_rd_ack, m_overrun and m_timeout are registered pulses, default 0 every cycle.
- States:
  - IDLE, no slot occupied: stay.
  - IDLE, winner is a write: drive bus_addr, bus_wr_data, bus_we=1 for one cycle; stay IDLE. Back-to-back writes issue every cycle.
  - IDLE, winner is a read: drive bus_addr, bus_re=1 for one cycle; owner <= winner; go WAIT_ACK.
  - WAIT_ACK: no new grants; capture continues. bus_rd_ack is sampled from the first cycle bus_re is high, so a combinational slave ack is legal. On bus_rd_ack: m_rd_data <= bus_rd_data, m_rd_ack[owner] pulses 1, go IDLE.
- Latency: request pulse sampled at edge T0 → bus pulse high during the cycle after edge T1 (2 cycles), when no other slot wins.
- Read round trip: bus ack sampled at edge Tk → m_rd_ack high the cycle after Tk.
- bus_rd_ack in IDLE (spurious): ignored.
- bus_addr and bus_wr_data hold their last values between transactions.
- m_rd_data holds until the next ack.

Optional Feature:
- Macro: BUS_ARB_TIMEOUT_EN.
- Defined:
  - WAIT_ACK counts cycles from entry.
  - If the count reaches TIMEOUT with no bus_rd_ack: m_rd_data <= all ones, m_rd_ack[owner] pulses, m_timeout pulses, go IDLE.
  - The counter clears on entry to WAIT_ACK.
  - Ack and timeout on the same edge: ack wins, real data returned.
- Undefined: no counter; WAIT_ACK waits indefinitely; m_timeout is constant 0.

Test Plan:
- Master 0 m_we pulse, addr 0x0010, data 0xA5A5_0001 → exactly one bus_we 2 cycles later with those values; no m_rd_ack.
- Master 1 m_re, addr 0x0020; slave acks 3 cycles after bus_re with 0x1234_5678 → m_rd_ack = 2'b10 one cycle after the ack, m_rd_data = 0x1234_5678; m_rd_ack[0] stays 0.
- Both masters pulse m_we on the same cycle, three times in a row after reset → bus grant order 0,1,0,1,… with rr alternating; no overrun as long as slots drain.
- Master 0 read outstanding with a slow ack; master 0 pulses m_we twice during WAIT_ACK → first write latched, second raises m_overrun[0]; after the ack the first write issues with its original data.
- With BUS_ARB_TIMEOUT_EN and TIMEOUT=8: read with no ack → 8 cycles after entering WAIT_ACK, m_rd_data=0xFFFF_FFFF, m_rd_ack and m_timeout pulse together; next pending request is then granted.
- reset_l dropped mid-WAIT_ACK, asynchronously between clk edges → all outputs 0 immediately; after release, a late bus_rd_ack produces no m_rd_ack.
